// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, ALU codes, mux selects, FSM states.
// The HALT state exists only when MULTICYCLE_ILLEGAL_TRAP_EN is defined.
package multicycle_controller_pkg;

    localparam int unsigned OP_W    = 7;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned IMM_W   = 3;
    localparam int unsigned ALUOP_W = 2;

    localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R    = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I    = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BR   = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL  = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR = 7'b1100111;
    localparam logic [OP_W-1:0] OP_LUI  = 7'b0110111;

    localparam logic [OPC_W-1:0] OPC_AND  = 3'b000;
    localparam logic [OPC_W-1:0] OPC_OR   = 3'b001;
    localparam logic [OPC_W-1:0] OPC_XOR  = 3'b010;
    localparam logic [OPC_W-1:0] OPC_ADD  = 3'b011;
    localparam logic [OPC_W-1:0] OPC_SUB  = 3'b100;
    localparam logic [OPC_W-1:0] OPC_SLT  = 3'b101;
    localparam logic [OPC_W-1:0] OPC_SLTU = 3'b110;

    localparam logic [IMM_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_W-1:0] IMM_S = 3'b001;
    localparam logic [IMM_W-1:0] IMM_B = 3'b010;
    localparam logic [IMM_W-1:0] IMM_J = 3'b011;
    localparam logic [IMM_W-1:0] IMM_U = 3'b100;

    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;
    localparam logic [SEL_W-1:0] RES_IMM    = 2'b11;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RD2   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_BR  = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FN  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JALR,
        S_JAL,
        S_LUI
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_e;

    // Branch condition from func3 and the ALU zero flag (SUB/SLT/SLTU result).
    function automatic logic branch_taken(input logic [F3_W-1:0] f3, input logic z);
        case (f3)
            3'b000, 3'b101, 3'b111: branch_taken = z;
            3'b001, 3'b100, 3'b110: branch_taken = ~z;
            default:                branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU operation decoder: fixed ADD, branch compare, or func3/func7_5 decode.
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [F3_W-1:0]    func3,
    input  logic               func7_5,
    input  logic               rtype,
    output logic [OPC_W-1:0]   opc
);

    always_comb begin
        opc = OPC_ADD;
        case (aluop)
            ALUOP_BR: begin
                case (func3)
                    3'b000, 3'b001: opc = OPC_SUB;
                    3'b100, 3'b101: opc = OPC_SLT;
                    3'b110, 3'b111: opc = OPC_SLTU;
                    default:        opc = OPC_ADD;
                endcase
            end
            ALUOP_FN: begin
                // func7_5 selects SUB only for register-register ops; addi ignores it.
                case (func3)
                    3'b000:  opc = (rtype && func7_5) ? OPC_SUB : OPC_ADD;
                    3'b100:  opc = OPC_XOR;
                    3'b110:  opc = OPC_OR;
                    3'b111:  opc = OPC_AND;
                    3'b010:  opc = OPC_SLT;
                    3'b011:  opc = OPC_SLTU;
                    default: opc = OPC_ADD;
                endcase
            end
            default: opc = OPC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: Moore decode of datapath enables/selects from state.
// Optional MULTICYCLE_ILLEGAL_TRAP_EN adds an `illegal` output and a HALT state for unknown opcodes.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    op,
    input  logic [F3_W-1:0]    func3,
    input  logic               func7_5,
    input  logic               zero,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [SEL_W-1:0]   ResultSrc,
    output logic [SEL_W-1:0]   ALUSrcA,
    output logic [SEL_W-1:0]   ALUSrcB,
    output logic               RegWrite,
    output logic [IMM_W-1:0]   ImmSrc,
    output logic [OPC_W-1:0]   opc
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    , output logic             illegal
`endif
);

    state_e               state_q;
    state_e               state_d;
    logic [ALUOP_W-1:0]   aluop;
    logic                 use_alu;
    logic [OPC_W-1:0]     dec_opc;
    logic                 pcupdate;
    logic                 branch;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR;
                    OP_LUI:       state_d = S_LUI;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    default:      state_d = S_HALT;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JALR:     state_d = S_JAL;
            S_JAL:      state_d = S_ALUWB;
            S_LUI:      state_d = S_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            S_HALT:     state_d = S_HALT;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // ALU operation class per state; states that do not drive the ALU leave opc at 000.
    always_comb begin
        aluop   = ALUOP_ADD;
        use_alu = 1'b0;
        case (state_q)
            S_FETCH, S_DECODE, S_MEMADR, S_JALR, S_JAL: use_alu = 1'b1;
            S_EXECR, S_EXECI: begin
                use_alu = 1'b1;
                aluop   = ALUOP_FN;
            end
            S_BRANCH: begin
                use_alu = 1'b1;
                aluop   = ALUOP_BR;
            end
            default: use_alu = 1'b0;
        endcase
    end

    multicycle_controller_alu_decoder u_alu_decoder (
        .aluop   (aluop),
        .func3   (func3),
        .func7_5 (func7_5),
        .rtype   (op == OP_R),
        .opc     (dec_opc)
    );

    // Moore output decode; reset masks every enable and parks the ALU on ADD.
    always_comb begin
        pcupdate  = 1'b0;
        branch    = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        RegWrite  = 1'b0;
        ImmSrc    = IMM_I;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                pcupdate  = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                if (op == OP_BR)       ImmSrc = IMM_B;
                else if (op == OP_JAL) ImmSrc = IMM_J;
                else                   ImmSrc = IMM_I;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_LW) ? IMM_I : IMM_S;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: ALUSrcA = SRCA_RD1;
            S_EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = SRCA_RD1;
                branch  = 1'b1;
            end
            S_JALR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_JAL: begin
                pcupdate = 1'b1;
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
            end
            S_LUI: begin
                ImmSrc    = IMM_U;
                ResultSrc = RES_IMM;
                RegWrite  = 1'b1;
            end
            default: pcupdate = 1'b0;
        endcase

        opc     = use_alu ? dec_opc : OPC_AND;
        PCWrite = pcupdate | (branch & branch_taken(func3, zero));

        if (rst) begin
            PCWrite   = 1'b0;
            AdrSrc    = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            ResultSrc = RES_ALUOUT;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_RD2;
            RegWrite  = 1'b0;
            ImmSrc    = IMM_I;
            opc       = OPC_ADD;
        end
    end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    assign illegal = (state_q == S_HALT) && !rst;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction expected output vectors are queued
// at issue and checked cycle by cycle. Define MULTICYCLE_ILLEGAL_TRAP_EN to cover the HALT trap.
module tb_multicycle_controller;

    typedef logic [17:0] vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] func3;
    logic       func7_5;
    logic       zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, opc;
    logic       ill_obs;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic       illegal;
    assign ill_obs = illegal;
`else
    assign ill_obs = 1'b0;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t sb_q[$];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .func3     (func3),
        .func7_5   (func7_5),
        .zero      (zero),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .RegWrite  (RegWrite),
        .ImmSrc    (ImmSrc),
        .opc       (opc)
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        , .illegal (illegal)
`endif
    );

    // {illegal, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite, ImmSrc, opc}
    function automatic vec_t mk(input logic pcw, input logic adr, input logic mw, input logic irw,
                                input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                                input logic rw, input logic [2:0] imm, input logic [2:0] oc);
        mk = {1'b0, pcw, adr, mw, irw, rs, sa, sb, rw, imm, oc};
    endfunction

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Starts at posedge+1; compares at each negedge and returns at posedge+1.
    task automatic run_cycles(input string name, input int n);
        vec_t exp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                check($sformatf("%s.c%0d.sb_empty", name, i + 1), 18'd1, 18'd0);
            end else begin
                exp = sb_q.pop_front();
                check($sformatf("%s.c%0d", name, i + 1),
                      {ill_obs, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                       RegWrite, ImmSrc, opc}, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    localparam vec_t V_RST    = {1'b0, 17'b0} | 18'd3;
    localparam vec_t V_FETCH  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0, 3'b000, 3'b011};
    localparam vec_t V_ALUWB  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 3'b000};
    localparam vec_t V_JAL    = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 3'b000, 3'b011};
    localparam vec_t V_HALT   = {1'b1, 17'b0};

    // Issues one instruction; xopc/xpcw are the hand-derived ALU code and branch PCWrite.
    task automatic instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                         input logic f75, input logic z, input logic [2:0] xopc, input logic xpcw);
        int n;
        op = o; func3 = f3; func7_5 = f75; zero = z;
        sb_q.push_back(V_FETCH);
        case (o)
            7'b0110011: begin
                sb_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b000, 3'b011));
                sb_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b000, xopc));
                sb_q.push_back(V_ALUWB);
            end
            7'b0010011: begin
                sb_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b000, 3'b011));
                sb_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, xopc));
                sb_q.push_back(V_ALUWB);
            end
            7'b0000011: begin
                sb_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b000, 3'b011));
                sb_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 3'b011));
                sb_q.push_back(mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000));
                sb_q.push_back(mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 3'b000, 3'b000));
            end
            7'b0100011: begin
                sb_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b000, 3'b011));
                sb_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b001, 3'b011));
                sb_q.push_back(mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000));
            end
            7'b1100011: begin
                sb_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b010, 3'b011));
                sb_q.push_back(mk(xpcw, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b000, xopc));
            end
            7'b1101111: begin
                sb_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b011, 3'b011));
                sb_q.push_back(V_JAL);
                sb_q.push_back(V_ALUWB);
            end
            7'b1100111: begin
                sb_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b000, 3'b011));
                sb_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 3'b011));
                sb_q.push_back(V_JAL);
                sb_q.push_back(V_ALUWB);
            end
            7'b0110111: begin
                sb_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b000, 3'b011));
                sb_q.push_back(mk(0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 3'b100, 3'b000));
            end
            default: begin
                sb_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b000, 3'b011));
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                for (int k = 0; k < 4; k++) sb_q.push_back(V_HALT);
`endif
            end
        endcase
        n = sb_q.size();
        run_cycles(name, n);
    endtask

    task automatic apply_reset(input string name);
        rst = 1'b1;
        sb_q.push_back(V_RST);
        run_cycles(name, 1);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; op = 7'd0; func3 = 3'd0; func7_5 = 1'b0; zero = 1'b0;
        @(posedge clk);
        #1;
        apply_reset("reset");

        instr("add",    7'b0110011, 3'b000, 1'b0, 1'b0, 3'b011, 1'b0);
        instr("sub",    7'b0110011, 3'b000, 1'b1, 1'b0, 3'b100, 1'b0);
        instr("addi30", 7'b0010011, 3'b000, 1'b1, 1'b0, 3'b011, 1'b0);
        instr("xor",    7'b0110011, 3'b100, 1'b0, 1'b0, 3'b010, 1'b0);
        instr("or",     7'b0110011, 3'b110, 1'b0, 1'b0, 3'b001, 1'b0);
        instr("and",    7'b0110011, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0);
        instr("slt",    7'b0110011, 3'b010, 1'b0, 1'b0, 3'b101, 1'b0);
        instr("sltiu",  7'b0010011, 3'b011, 1'b1, 1'b0, 3'b110, 1'b0);
        instr("srli",   7'b0010011, 3'b101, 1'b0, 1'b0, 3'b011, 1'b0);
        instr("lw",     7'b0000011, 3'b010, 1'b0, 1'b0, 3'b011, 1'b0);
        instr("sw",     7'b0100011, 3'b010, 1'b0, 1'b0, 3'b011, 1'b0);
        instr("beq_z1", 7'b1100011, 3'b000, 1'b0, 1'b1, 3'b100, 1'b1);
        instr("beq_z0", 7'b1100011, 3'b000, 1'b0, 1'b0, 3'b100, 1'b0);
        instr("bne_z1", 7'b1100011, 3'b001, 1'b0, 1'b1, 3'b100, 1'b0);
        instr("blt_z0", 7'b1100011, 3'b100, 1'b0, 1'b0, 3'b101, 1'b1);
        instr("bge_z0", 7'b1100011, 3'b101, 1'b0, 1'b0, 3'b101, 1'b0);
        instr("bltu_z0",7'b1100011, 3'b110, 1'b0, 1'b0, 3'b110, 1'b1);
        instr("bgeu_z1",7'b1100011, 3'b111, 1'b0, 1'b1, 3'b110, 1'b1);
        instr("jal",    7'b1101111, 3'b000, 1'b0, 1'b0, 3'b011, 1'b0);
        instr("jalr",   7'b1100111, 3'b000, 1'b0, 1'b0, 3'b011, 1'b0);
        instr("lui",    7'b0110111, 3'b000, 1'b0, 1'b0, 3'b011, 1'b0);

        // Reset asserted while in MEMWRITE: write suppressed, FETCH next.
        op = 7'b0100011; func3 = 3'b010; func7_5 = 1'b0; zero = 1'b0;
        sb_q.push_back(V_FETCH);
        sb_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b000, 3'b011));
        sb_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b001, 3'b011));
        run_cycles("sw_rst", 3);
        apply_reset("sw_rst.memwrite");
        instr("add_after_rst", 7'b0110011, 3'b000, 1'b0, 1'b0, 3'b011, 1'b0);

        instr("unknown", 7'b0000000, 3'b000, 1'b0, 1'b0, 3'b011, 1'b0);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        apply_reset("halt_rst");
`endif
        instr("add_final", 7'b0110011, 3'b000, 1'b0, 1'b0, 3'b011, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multicycle RV32I control FSM. It drives the datapath ALU: it sends the 3-bit opc and receives zero. From the opcode/func fields in the instruction register it sequences fetch, decode, execute, memory and writeback, and it produces every datapath enable and mux select.

Parameters:
None. All encodings are fixed constants in the shared package.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
op  in  7  instr[6:0]
func3  in  3  instr[14:12]
func7_5  in  1  instr[30]
zero  in  1  ALU result == 0
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address: 0=PC, 1=Result
MemWrite  out  1  data memory write
IRWrite  out  1  IR/OldPC capture
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt
ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
ALUSrcB  out  2  00=RD2, 01=ImmExt, 10=const 4
RegWrite  out  1  register file write
ImmSrc  out  3  000=I, 001=S, 010=B, 011=J, 100=U
opc  out  3  ALU op: AND 000, OR 001, XOR 010, ADD 011, SUB 100, SLT 101, SLTU 110

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high. On a clk edge with rst=1, state<=FETCH.
- Outputs while rst=1: PCWrite, MemWrite, IRWrite and RegWrite forced to 0. Every other output is 0. opc=ADD.
- All outputs are Moore, decoded from state only. Exception: PCWrite = PCUpdate | (Branch & taken).
- Unlisted outputs are 0 in each state.
- States and actions:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, opc=ADD, ResultSrc=10, PCUpdate=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, opc=ADD (ALUOut=OldPC+imm), ImmSrc=B for branch, J for jal, I otherwise. Next by op:
    - 0000011/0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - any other -> FETCH (NOP)
  - MEMADR: ALUSrcA=10, ALUSrcB=01, opc=ADD, ImmSrc=I (lw) or S (sw). Next: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, opc from alu_decoder. Next: ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, opc from alu_decoder. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00, Branch=1. Next: FETCH.
    - func3 000 beq: opc=SUB, taken=zero
    - func3 001 bne: opc=SUB, taken=~zero
    - func3 100 blt: opc=SLT, taken=~zero
    - func3 101 bge: opc=SLT, taken=zero
    - func3 110 bltu: opc=SLTU, taken=~zero
    - func3 111 bgeu: opc=SLTU, taken=zero
    - func3 010/011: taken=0
  - JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, opc=ADD (ALUOut=rs1+imm). Next: JAL.
  - JAL: ResultSrc=00, PCUpdate=1, ALUSrcA=01, ALUSrcB=10, opc=ADD (ALUOut=OldPC+4). Next: ALUWB.
  - LUI: ImmSrc=U, ResultSrc=11, RegWrite=1. Next: FETCH.
- alu_decoder mapping:
  - R-type (op 0110011) by func3: 000 -> ADD, or SUB when func7_5=1; 100 XOR; 110 OR; 111 AND; 010 SLT; 011 SLTU.
  - I-type (op 0010011): same mapping, but func7_5 is ignored (addi is always ADD).
  - Unsupported func3 -> ADD.
- Cycle counts: R/I-ALU 4, lw 5, sw 4, branch 3, jal 4, jalr 5, lui 3.
- Reset mid-instruction: the pending write is suppressed in the rst cycle, and the next state is FETCH.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: adds output `illegal` (1 bit) and state HALT. An unknown op in DECODE goes to HALT. In HALT, `illegal`=1, all enables are 0, and the FSM stays there until rst.
- Undefined: no `illegal` port and no HALT state. An unknown op is a NOP that returns to FETCH.

Decomposition:
- Shared package: opcode constants, ALU opc codes (AND..SLTU), ImmSrc/ResultSrc/ALUSrcA/ALUSrcB encodings, state encoding.
- One sub-module, alu_decoder (combinational): inputs aluop (00 ADD, 01 branch, 10 func-decode), func3, func7_5 and an R/I flag; output opc.

Test Plan:
- add x3,x1,x2, func7_5=0 -> states FETCH,DECODE,EXECR,ALUWB; opc=011 in EXECR; RegWrite=1 exactly in cycle 4.
- sub (func7_5=1) -> opc=100. addi with instr[30]=1 -> opc=011.
- lw -> 5 cycles, AdrSrc=1 in MEMREAD, ResultSrc=01 in MEMWB. sw -> MemWrite=1 for exactly 1 cycle, RegWrite never asserted.
- beq with zero=1 -> PCWrite=1 in BRANCH. Same with zero=0 -> PCWrite=0.
- bltu with zero=0 -> opc=110 and PCWrite=1. bge with zero=0 -> PCWrite=0.
- jalr -> JALR then JAL, PCWrite=1 in JAL, RegWrite=1 in ALUWB, 5 cycles total.
- rst asserted during MEMWRITE -> MemWrite=0 that cycle, FETCH next.
- Unknown op 0000000 -> returns to FETCH; with MULTICYCLE_ILLEGAL_TRAP_EN, `illegal`=1 and the FSM holds until rst.
